// File: rtl/univ_shift_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// univ_shift_reg : universal shift register (load/shift/rotate/asr/clear)
//                  with a per-frame shift counter and frame_done pulse.
// Revision: 1.0
// ---------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             frame_done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shift_op;

  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shift_op = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD:  data_d = data_q;
        MODE_LOAD:  begin data_d = d;  cnt_d = '0; end
        MODE_SHL:   begin data_d = {data_q[WIDTH-2:0], sin_r};         shift_op = 1'b1; end
        MODE_SHR:   begin data_d = {sin_l, data_q[WIDTH-1:1]};         shift_op = 1'b1; end
        MODE_ROTL:  begin data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]}; shift_op = 1'b1; end
        MODE_ROTR:  begin data_d = {data_q[0], data_q[WIDTH-1:1]};     shift_op = 1'b1; end
        MODE_ASR:   begin data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]}; shift_op = 1'b1; end
        MODE_CLEAR: begin data_d = '0; cnt_d = '0; end
        default:    data_d = data_q;
      endcase
    end
    // Explicit wrap keeps the count below WIDTH even when WIDTH is not a power of two.
    if (shift_op) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q          = data_q;
  assign qb         = ~data_q;
  assign sout_l     = data_q[WIDTH-1];
  assign sout_r     = data_q[0];
  assign shift_cnt  = cnt_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_univ_shift_reg : directed + randomized bench against an arithmetic model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_univ_shift_reg;
  localparam int WIDTH = 8;
  localparam int CW    = 3;
  localparam int unsigned MASK = (32'd1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_l, sin_r;
  logic [WIDTH-1:0] q, qb;
  logic             sout_l, sout_r;
  logic [CW-1:0]    shift_cnt;
  logic             frame_done;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .q(q), .qb(qb),
    .sout_l(sout_l), .sout_r(sout_r), .shift_cnt(shift_cnt),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned m_q, m_cnt;
  bit          m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"},          32'(q),          m_q);
    chk({tag, ".qb"},         32'(qb),         ~m_q & MASK);
    chk({tag, ".sout_l"},     32'(sout_l),     (m_q >> (WIDTH-1)) & 1);
    chk({tag, ".sout_r"},     32'(sout_r),     m_q & 1);
    chk({tag, ".shift_cnt"},  32'(shift_cnt),  m_cnt);
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(m_done));
  endtask

  task automatic model_reset();
    m_q = 0; m_cnt = 0; m_done = 0;
  endtask

  // Next state from the current inputs, computed with plain arithmetic.
  task automatic model_step();
    bit is_shift;
    m_done = 0;
    if (!en) return;
    is_shift = (mode >= 3'd2) && (mode <= 3'd6);
    case (mode)
      3'd1: begin m_q = 32'(d); m_cnt = 0; end
      3'd2: m_q = ((m_q << 1) | 32'(sin_r)) & MASK;
      3'd3: m_q = (32'(sin_l) << (WIDTH-1)) | (m_q >> 1);
      3'd4: m_q = ((m_q << 1) | (m_q >> (WIDTH-1))) & MASK;
      3'd5: m_q = ((m_q & 1) << (WIDTH-1)) | (m_q >> 1);
      3'd6: m_q = (m_q & (32'd1 << (WIDTH-1))) | (m_q >> 1);
      3'd7: begin m_q = 0; m_cnt = 0; end
      default: ;
    endcase
    if (is_shift) begin
      m_done = (m_cnt == WIDTH-1);
      m_cnt  = (m_cnt + 1) % WIDTH;
    end
  endtask

  task automatic op(input bit e, input logic [2:0] m, input logic [7:0] dd,
                    input bit sl, input bit sr, input string tag);
    en = e; mode = m; d = dd; sin_l = sl; sin_r = sr;
    model_step();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  // Asserted mid-cycle so the clear must be asynchronous.
  task automatic reset_pulse(input string tag);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all({tag, ".async"});
    for (int i = 0; i < 2; i++) begin
      en = 1'b1; mode = 3'($urandom_range(1, 6)); d = 8'($urandom);
      sin_l = 1'b1; sin_r = 1'b1;
      @(posedge clk); #1;
      check_all({tag, ".held"});
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 3'd0; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    #1 model_reset();
    check_all("por");
    @(posedge clk); #1;
    rst = 1'b1;

    // Load then shl with sin_r=1.
    op(1, 3'd1, 8'hA5, 0, 0, "load_a5");
    op(1, 3'd2, 8'h00, 0, 1, "shl");
    chk("shl_q", 32'(q), 32'h4B);
    chk("shl_sout_l", 32'(sout_l), 32'd0);
    chk("shl_cnt", 32'(shift_cnt), 32'd1);

    // Reset while holding a nonzero value.
    reset_pulse("rst_mid");

    // Load then 8 rotr: value returns, frame_done for exactly one cycle.
    op(1, 3'd1, 8'h81, 0, 0, "load_81");
    for (int i = 0; i < 8; i++) op(1, 3'd5, 8'h00, 0, 0, "rotr");
    chk("rotr8_q", 32'(q), 32'h81);
    chk("rotr8_done", 32'(frame_done), 32'd1);
    chk("rotr8_cnt", 32'(shift_cnt), 32'd0);
    op(1, 3'd0, 8'h00, 0, 0, "hold_after_frame");
    chk("done_one_cycle", 32'(frame_done), 32'd0);

    // asr x3 then shr with sin_l=0.
    op(1, 3'd1, 8'h80, 0, 0, "load_80");
    for (int i = 0; i < 3; i++) op(1, 3'd6, 8'h00, 0, 0, "asr");
    chk("asr3_q", 32'(q), 32'hF0);
    op(1, 3'd3, 8'h00, 0, 0, "shr");
    chk("shr_q", 32'(q), 32'h78);

    // en=0 with clear mode must hold everything.
    for (int i = 0; i < 5; i++) op(0, 3'd7, 8'hFF, 1, 1, "en0_clear");
    chk("en0_q", 32'(q), 32'h78);
    chk("en0_cnt", 32'(shift_cnt), 32'd4);

    // Partial frame discarded by reset.
    for (int i = 0; i < 5; i++) op(1, 3'd2, 8'h00, 0, 1, "pre_rst_shl");
    reset_pulse("rst_frame");
    for (int i = 0; i < 8; i++) begin
      op(1, 3'd4, 8'h00, 0, 0, "post_rst_rotl");
      chk("post_rst_done", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
    end

    // Load and clear zero the count without a frame pulse.
    for (int i = 0; i < 7; i++) op(1, 3'd2, 8'h00, 0, 1, "pre_load_shl");
    op(1, 3'd1, 8'h3C, 0, 0, "load_zero_cnt");
    chk("load_no_done", 32'(frame_done), 32'd0);
    for (int i = 0; i < 7; i++) op(1, 3'd3, 8'h00, 1, 0, "pre_clr_shr");
    op(1, 3'd7, 8'h00, 0, 0, "clear_zero_cnt");
    chk("clear_q", 32'(q), 32'd0);

    // Randomized operation mix with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 60) == 0) reset_pulse("rnd_rst");
      op(($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom),
         1'($urandom), 1'($urandom), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits; legal range 2..32.
REQ-002 The block SHALL have localparam CW = $clog2(WIDTH), default 3, meaning shift-counter width.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port en  input  1  operation enable; 0 = hold all state.
REQ-006 The block SHALL have port mode  input  3  operation select, encoded per REQ-011.
REQ-007 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-008 The block SHALL have ports sin_l and sin_r  input  1 each  serial-in at MSB side and at LSB side.
REQ-009 The block SHALL have ports q and qb  output  WIDTH each  register value and its bitwise complement.
REQ-010 The block SHALL have ports sout_l, sout_r  output  1; shift_cnt  output  CW; frame_done  output  1.

Function
REQ-011 When en=1, q SHALL update on rising clk as follows:
- 000 hold
- 001 load, q<=d
- 010 shl, q<={q[W-2:0],sin_r}
- 011 shr, q<={sin_l,q[W-1:1]}
- 100 rotl, q<={q[W-2:0],q[W-1]}
- 101 rotr, q<={q[0],q[W-1:1]}
- 110 asr, q<={q[W-1],q[W-1:1]}
- 111 clear, q<=0
REQ-012 When en=0, q and shift_cnt SHALL hold regardless of mode.
REQ-013 qb SHALL equal ~q at all times, including during and after reset.
REQ-014 sout_l SHALL equal q[W-1] and sout_r SHALL equal q[0], combinationally from q.
REQ-015 Modes 010..110 with en=1 SHALL be "shift ops"; each shift op SHALL increment shift_cnt by 1.
REQ-016 A shift op at shift_cnt=WIDTH-1 SHALL wrap shift_cnt to 0 and register frame_done=1 for exactly the following cycle.
REQ-017 frame_done SHALL be 0 in every cycle not covered by REQ-016, including cycles with en=0.
REQ-018 Load (001) and clear (111) with en=1 SHALL set shift_cnt to 0 and SHALL NOT assert frame_done.
REQ-019 Hold (000) SHALL leave shift_cnt unchanged.
REQ-020 For non-power-of-2 WIDTH, shift_cnt SHALL never exceed WIDTH-1.
REQ-021 Latency: every registered output (q, qb, shift_cnt, frame_done) SHALL reflect an operation one clk edge after it is sampled.

Reset
REQ-022 rst=0 SHALL immediately, without waiting for clk, force q=0, qb=all ones, shift_cnt=0, frame_done=0.
REQ-023 While rst=0, all inputs SHALL be ignored.
REQ-024 A reset asserted mid-frame SHALL discard the partial shift count.
REQ-025 Normal operation SHALL resume at the first rising clk after rst returns to 1.

Verification (WIDTH=8)
REQ-026 The bench SHALL cover: reset -> q=8'h00, qb=8'hFF, shift_cnt=0, frame_done=0, asserted asynchronously between clock edges.
REQ-027 The bench SHALL cover: load d=8'hA5, then shl with sin_r=1 -> q=8'h4B, sout_l=0, shift_cnt=1.
REQ-028 The bench SHALL cover: load 8'h81, then rotr x8 -> q=8'h81 after the 8th op, frame_done=1 for one cycle only, shift_cnt=0.
REQ-029 The bench SHALL cover: load 8'h80, then asr x3 -> q=8'hF0; then shr with sin_l=0 -> q=8'h78.
REQ-030 The bench SHALL cover: en=0 with mode=111 for 5 cycles -> q and shift_cnt unchanged, frame_done=0.
REQ-031 The bench SHALL cover: 5 shift ops, then rst pulse, then 8 shift ops -> frame_done only after the 8th post-reset shift.
